// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode types: opcodes, format classes, fetch entries.
// Also carries the opcode classifier so decode can reuse it.
package instr_fetch_unit_pkg;

  localparam int PROGRAM_ADDRESS_WIDTH = 8;
  localparam int INSTRUCTION_WIDTH = 32;

  typedef logic [PROGRAM_ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [INSTRUCTION_WIDTH-1:0] word_t;

  localparam word_t NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    LOAD     = 7'b0000011,
    LOAD_FP  = 7'b0000111,
    OP_IMM   = 7'b0010011,
    U_AUIPC  = 7'b0010111,
    STORE    = 7'b0100011,
    STORE_FP = 7'b0100111,
    OP       = 7'b0110011,
    U_LUI    = 7'b0110111,
    MADD     = 7'b1000011,
    MSUB     = 7'b1000111,
    NMSUB    = 7'b1001011,
    NMADD    = 7'b1001111,
    OP_FP    = 7'b1010011,
    BRANCH   = 7'b1100011,
    JALR     = 7'b1100111,
    J_JAL    = 7'b1101111,
    SYSTEM   = 7'b1110011
  } instruction_format_type;

  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE,
    SYS_TYPE
  } instruction_op_type;

  typedef struct packed {
    word_t instr;
    addr_t pc;
  } fetch_entry_t;

  typedef struct packed {
    instruction_op_type fmt;
    logic               illegal;
  } fmt_info_t;

  function automatic fmt_info_t op_class(logic [6:0] opcode);
    fmt_info_t r;
    r.fmt = R_TYPE;
    r.illegal = 1'b0;
    case (opcode)
      OP, OP_FP, MADD,
      MSUB, NMSUB, NMADD:  r.fmt = R_TYPE;
      OP_IMM, JALR,
      LOAD, LOAD_FP:       r.fmt = I_TYPE;
      STORE, STORE_FP:     r.fmt = S_TYPE;
      BRANCH:              r.fmt = B_TYPE;
      U_AUIPC, U_LUI:      r.fmt = U_TYPE;
      J_JAL:               r.fmt = J_TYPE;
      SYSTEM:              r.fmt = SYS_TYPE;
      default:             r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake: head instruction, PC and pre-decode.
// master = fetch side, slave = decode side.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  word_t              instr;
  addr_t              instr_pc;
  instruction_op_type instr_fmt;
  logic               instr_illegal;

  modport master (
    output instr_valid,
    output instr,
    output instr_pc,
    output instr_fmt,
    output instr_illegal,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  instr_pc,
    input  instr_fmt,
    input  instr_illegal,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO of fetch entries; flush wins over push.
// Supports any depth 2..4 (pointers wrap explicitly).
module if_prefetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: issues program-memory reads, buffers returned words,
// presents them to decode and restarts on EX redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int    FIFO_DEPTH = 2,
  parameter addr_t RESET_PC   = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_en,
  output addr_t                     imem_addr,
  input  word_t                     imem_rdata,
  input  logic                      redirect_valid,
  input  addr_t                     redirect_pc,
  instr_fetch_unit_if.master        dec
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  addr_t         pc;
  logic          epoch;
  logic          req_q;
  logic          req_epoch;
  addr_t         req_addr;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  din;
  fmt_info_t     info;
  logic          pop;
  logic          push;
  logic [3:0]    occ;
  addr_t         tgt;

  assign tgt = redirect_pc & 8'hFC;
  assign dec.instr_valid = (count != '0);
  assign pop = dec.instr_valid && dec.instr_ready;

  // A pop this cycle frees a slot, letting fetch stream one word per cycle.
  assign occ  = 4'(count) + 4'(req_q) - 4'(pop);
  assign push = req_q && (req_epoch == epoch);
  assign din  = '{instr: imem_rdata, pc: req_addr};

  always_comb begin
    imem_en   = 1'b0;
    imem_addr = pc;
    if (rst) begin
      if (redirect_valid) begin
        imem_en   = 1'b1;
        imem_addr = tgt;
      end else if (occ < 4'(FIFO_DEPTH)) begin
        imem_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      epoch     <= 1'b0;
      req_q     <= 1'b0;
      req_epoch <= 1'b0;
      req_addr  <= RESET_PC;
    end else begin
      if (redirect_valid) epoch <= !epoch;
      if (imem_en) begin
        pc       <= imem_addr + 8'd4;
        req_addr <= imem_addr;
      end
      req_q     <= imem_en;
      req_epoch <= redirect_valid ? !epoch : epoch;
    end
  end

  if_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

  // An empty FIFO shows a NOP at RESET_PC so decode never sees junk.
  always_comb begin
    dec.instr    = NOP_INSTR;
    dec.instr_pc = RESET_PC;
    if (dec.instr_valid) begin
      dec.instr    = head.instr;
      dec.instr_pc = head.pc;
    end
  end

  assign info              = op_class(dec.instr[6:0]);
  assign dec.instr_fmt     = info.fmt;
  assign dec.instr_illegal = info.illegal;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a delivered-PC scoreboard.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  imem_en;
  addr_t imem_addr;
  word_t imem_rdata = '0;
  logic  redirect_valid;
  addr_t redirect_pc;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .FIFO_DEPTH (2),
    .RESET_PC   (8'h00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (bus.master)
  );

  always #5 clk = ~clk;

  function automatic word_t mem_word(addr_t a);
    case (a)
      8'hB0:   return 32'h0000_0013;
      8'hB4:   return 32'h0000_006F;
      8'hB8:   return 32'h0000_007F;
      default: return {a, 8'h00, 16'h0013};
    endcase
  endfunction

  always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);

  int    n_vec;
  int    n_err;
  addr_t exp_q[$];
  logic  s_en;
  addr_t s_addr;
  logic  s_valid;
  addr_t s_pc;
  logic  s_ill;
  instruction_op_type s_fmt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, score any accepted word, end after posedge.
  task automatic cyc();
    addr_t e;
    @(negedge clk);
    s_en    = imem_en;
    s_addr  = imem_addr;
    s_valid = bus.instr_valid;
    s_pc    = bus.instr_pc;
    s_fmt   = bus.instr_fmt;
    s_ill   = bus.instr_illegal;
    if (bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 32'(bus.instr_pc), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", 32'(bus.instr_pc), 32'(e));
        chk("pop_instr", bus.instr, mem_word(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus.instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_en", 32'(s_en), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'h00);
    chk("rst_instr", bus.instr, NOP_INSTR);
    chk("rst_pc", 32'(s_pc), 32'h00);
    chk("rst_fmt", 32'(s_fmt), 32'(I_TYPE));
    chk("rst_ill", 32'(s_ill), 32'd0);

    // streaming with ready held high
    rst = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(addr_t'(4 * i));
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("seq_en", 32'(s_en), 32'd1);
      chk("seq_addr", 32'(s_addr), 32'(4 * k));
      if (k < 2) chk("seq_latency", 32'(s_valid), 32'd0);
      else if (k == 2) chk("first_valid", 32'(s_valid), 32'd1);
    end
    chk("drain_seq", 32'(exp_q.size()), 32'd0);

    // reset mid-stream with a read in flight
    rst = 1'b0;
    #1;
    chk("mid_rst_en", 32'(imem_en), 32'd0);
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'h00);
    chk("mid_rst_pc", 32'(bus.instr_pc), 32'h00);
    cyc();
    cyc();

    // backpressure from release
    bus.instr_ready = 1'b0;
    rst = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h0C);
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k >= 2) begin
        chk("bp_en", 32'(s_en), 32'd0);
        chk("bp_valid", 32'(s_valid), 32'd1);
        chk("bp_head", 32'(s_pc), 32'h00);
      end
    end
    bus.instr_ready = 1'b1;
    cyc();
    chk("bp_resume_en", 32'(s_en), 32'd1);
    chk("bp_resume_addr", 32'(s_addr), 32'h08);
    repeat (3) cyc();
    chk("drain_bp", 32'(exp_q.size()), 32'd0);

    // redirect while FIFO holds two entries
    exp_q.push_back(8'h10);
    bus.instr_ready = 1'b0;
    cyc();
    cyc();
    chk("full_en", 32'(s_en), 32'd0);
    chk("full_head", 32'(s_pc), 32'h10);
    redirect_valid = 1'b1;
    redirect_pc = 8'h43;
    bus.instr_ready = 1'b1;
    cyc();
    chk("redir_en", 32'(s_en), 32'd1);
    chk("redir_addr", 32'(s_addr), 32'h40);
    redirect_valid = 1'b0;
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h4C);
    cyc();
    chk("redir_bubble", 32'(s_valid), 32'd0);
    repeat (4) cyc();
    chk("drain_redir", 32'(exp_q.size()), 32'd0);

    // back-to-back redirects
    exp_q.push_back(8'h50);
    redirect_valid = 1'b1;
    redirect_pc = 8'h20;
    cyc();
    chk("b2b_addr0", 32'(s_addr), 32'h20);
    redirect_pc = 8'h80;
    cyc();
    chk("b2b_addr1", 32'(s_addr), 32'h80);
    chk("b2b_bubble0", 32'(s_valid), 32'd0);
    redirect_valid = 1'b0;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h84);
    exp_q.push_back(8'h88);
    cyc();
    chk("b2b_bubble1", 32'(s_valid), 32'd0);
    repeat (3) cyc();
    chk("drain_b2b", 32'(exp_q.size()), 32'd0);

    // address wrap F8 -> FC -> 00
    exp_q.push_back(8'h8C);
    exp_q.push_back(8'hF8);
    exp_q.push_back(8'hFC);
    exp_q.push_back(8'h00);
    redirect_valid = 1'b1;
    redirect_pc = 8'hF8;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("wrap_addr_fc", 32'(s_addr), 32'hFC);
    cyc();
    chk("wrap_addr_00", 32'(s_addr), 32'h00);
    repeat (2) cyc();
    chk("drain_wrap", 32'(exp_q.size()), 32'd0);

    // pre-decode: NOP, JAL, illegal opcode
    exp_q.push_back(8'h04);
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hB4);
    exp_q.push_back(8'hB8);
    redirect_valid = 1'b1;
    redirect_pc = 8'hB2;
    cyc();
    chk("fmt_redir_addr", 32'(s_addr), 32'hB0);
    redirect_valid = 1'b0;
    cyc();
    chk("fmt_bubble", 32'(s_valid), 32'd0);
    cyc();
    chk("fmt_nop", 32'(s_fmt), 32'(I_TYPE));
    chk("fmt_nop_ill", 32'(s_ill), 32'd0);
    cyc();
    chk("fmt_jal", 32'(s_fmt), 32'(J_TYPE));
    chk("fmt_jal_ill", 32'(s_ill), 32'd0);
    cyc();
    chk("fmt_bad_ill", 32'(s_ill), 32'd1);
    chk("fmt_bad_fmt", 32'(s_fmt), 32'(R_TYPE));
    bus.instr_ready = 1'b0;
    cyc();
    chk("drain_fmt", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the pipeline: drives the program-memory read port and buffers returned words in a small prefetch FIFO.
- Presents instructions, with their PC and a pre-decoded format class, to the decode stage over a valid/ready handshake.
- Accepts branch/jump redirects from EX, flushing buffered and in-flight fetches.

Parameters:
- FIFO_DEPTH, 2, prefetch entries; legal values 2..4.
- RESET_PC, 8'h00, PC after reset; must be word aligned.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-low reset; asserted when rst == RESET.
- imem_en  output  1  read strobe to program memory.
- imem_addr  output  PROGRAM_ADDRESS_WIDTH  byte address of the read; bits [1:0] always 0.
- imem_rdata  input  INSTRUCTION_WIDTH  read data; valid exactly one cycle after imem_en.
- redirect_valid  input  1  EX stage requests a PC change.
- redirect_pc  input  PROGRAM_ADDRESS_WIDTH  redirect target; bits [1:0] ignored.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr_ready  input  1  decode accepts the head this cycle.
- instr  output  INSTRUCTION_WIDTH  instruction word at the head.
- instr_pc  output  PROGRAM_ADDRESS_WIDTH  PC of the head.
- instr_fmt  output  instruction_op_type  format class of the head.
- instr_illegal  output  1  head opcode is not an instruction_format_type value.

Behaviour:
- Reset (async, rst == RESET):
  - pc = RESET_PC, FIFO empty, no fetch in flight.
  - instr_valid = 0, imem_en = 0, imem_addr = RESET_PC.
  - instr = NOP_INSTR (32'h0000_0013), instr_pc = RESET_PC, instr_fmt = I_TYPE, instr_illegal = 0.
- Issue rule:
  - imem_en = 1 when (count + inflight) < FIFO_DEPTH, or when redirect_valid = 1.
  - On issue, imem_addr = pc, then pc <= pc + 4.
  - pc wraps modulo 2^PROGRAM_ADDRESS_WIDTH (8'hFC + 4 -> 8'h00).
- Response: the cycle after issue, imem_rdata and the issued address are pushed into the FIFO, unless the fetch was killed.
- Latency:
  - A word issued in cycle N is pushed at the end of N+1 and visible at the head in N+2.
  - After reset deassertion, the first instr_valid occurs in cycle 2.
- Handshake:
  - The head is popped when instr_valid && instr_ready.
  - instr, instr_pc and instr_fmt hold stable while instr_valid && !instr_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Redirect (highest priority):
  - In the redirect cycle, imem_addr = {redirect_pc[7:2], 2'b00} with imem_en = 1, and pc <= target + 4.
  - At the clock edge the FIFO is cleared and any response arriving next cycle from an earlier issue is killed.
  - instr_valid = 0 in the cycle after the redirect; the target instruction appears in cycle redirect + 2.
  - An instr_ready pop in the redirect cycle is still honoured; that entry is consumed, not replayed.
- Kill tracking: a 1-bit epoch toggles on redirect. Each in-flight tag carries the epoch; a mismatching response is dropped.
- Full FIFO: no issue; pc holds. Responses never overflow because the issue rule counts in-flight reads.
- Back-to-back redirects: each one re-issues to its own target; only the last target's word survives.
- Pre-decode (combinational from the head opcode [6:0]):
  - OP, OP_FP, MADD, MSUB, NMSUB, NMADD -> R_TYPE.
  - OP_IMM, JALR, LOAD, LOAD_FP -> I_TYPE.
  - STORE, STORE_FP -> S_TYPE.
  - BRANCH -> B_TYPE.
  - U_AUIPC, U_LUI -> U_TYPE.
  - J_JAL -> J_TYPE.
  - SYSTEM -> SYS_TYPE.
  - Any other opcode -> instr_fmt = R_TYPE, instr_illegal = 1 (only meaningful when instr_valid).
- Reset mid-operation: state clears immediately; any memory response arriving after reset deassertion is ignored because inflight was cleared.

Decomposition:
- Add to package common:
  - NOP_INSTR constant.
  - fetch_entry_t struct {instr, pc}.
  - Opcode-to-instruction_op_type mapping function, so decode can share it.
- Sub-module if_prefetch_fifo:
  - Parameterised depth, fetch_entry_t payload.
  - push, pop, flush, count, head.
  - Flush has priority over push.

Test Plan:
- Release reset with instr_ready = 1 and memory returning word = addr-tagged values -> imem_addr 00, 04, 08... each cycle; instr_valid first high in cycle 2 with instr_pc = 00; instr_pc increments by 4 every cycle.
- Hold instr_ready = 0 from cycle 2 -> at most FIFO_DEPTH words buffered, imem_en low afterwards, head stable at pc 00; raise ready -> 00, 04 delivered in order, fetching resumes at 08.
- redirect_valid with redirect_pc = 8'h43 while FIFO holds 2 entries -> imem_addr = 8'h40 that cycle; instr_valid = 0 next cycle; next delivered instr_pc = 8'h40, then 8'h44; no stale PCs.
- Two redirects in consecutive cycles (8'h20, then 8'h80) -> only 8'h80, 8'h84, ... delivered.
- Sequential fetch from 8'hF8 -> PCs F8, FC, 00.
- Memory returns 32'h0000_0013, 32'h0000_006F, 32'h0000_007F -> instr_fmt I_TYPE, J_TYPE, then instr_illegal = 1.
- Assert rst mid-stream with a fetch in flight -> outputs at reset values immediately; after release, the first delivered instr_pc = RESET_PC.
